gpio_cfg_sequencer: RTL and testbench

Sequences the serial configuration chain of the user-project GPIO pad array. Each pad has a per-pad control block that holds one CFG_BITS-bit word, and these blocks form one daisy chain. On a start pulse, the block fetches each pad's word from a config store, shifts the words serially onto the chain at a divided bit rate, then pulses a load strobe so every pad latches its word at once. It sits between housekeeping (config store plus start/done) and the pad-control chain that feeds io_out/oeb/inp_dis/dm into the pad array.

---
 rtl/gpio_cfg_sequencer_if.sv | 31 +++
 rtl/gpio_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_gpio_cfg_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_sequencer_if.sv
// Config-store and pad-chain bundle for gpio_cfg_sequencer.
// master: the sequencer; slave: housekeeping store plus the pad control chain.
interface gpio_cfg_sequencer_if #(
  parameter int unsigned TOTAL_PADS = 38,
  parameter int unsigned CFG_BITS   = 13
);
  localparam int unsigned AddrW = $clog2(TOTAL_PADS);

  logic                start;
  logic                busy;
  logic                done;
  logic                cfg_rd;
  logic [AddrW-1:0]    cfg_addr;
  logic [CFG_BITS-1:0] cfg_data;
  logic                serial_clock;
  logic                serial_data_out;
  logic                serial_load;
  logic                serial_resetn;

  modport master (
    input  start, cfg_data,
    output busy, done, cfg_rd, cfg_addr,
    output serial_clock, serial_data_out, serial_load, serial_resetn
  );

  modport slave (
    output start, cfg_data,
    input  busy, done, cfg_rd, cfg_addr,
    input  serial_clock, serial_data_out, serial_load, serial_resetn
  );
endinterface

// File: rtl/gpio_cfg_sequencer.sv
// GPIO pad configuration chain sequencer.
// Fetches one CFG_BITS word per pad (highest pad first), shifts it MSB first onto the
// serial chain at a CLK_DIV-divided bit rate, then pulses serial_load once.
// Optional build macro GPIO_CFG_AUTOSTART_EN: one implicit pass after every reset release.
module gpio_cfg_sequencer #(
  parameter int unsigned TOTAL_PADS = 38,
  parameter int unsigned CFG_BITS   = 13,
  parameter int unsigned CLK_DIV    = 2
) (
  input logic                  clock,
  input logic                  resetn,
  gpio_cfg_sequencer_if.master bus
);
  localparam int unsigned AddrW = $clog2(TOTAL_PADS);
  localparam int unsigned CntW  = $clog2(CFG_BITS);
  localparam int unsigned DivW  = $clog2(CLK_DIV + 1);

  localparam logic [AddrW-1:0] LastPad = AddrW'(TOTAL_PADS - 1);
  localparam logic [CntW-1:0]  LastBit = CntW'(CFG_BITS - 1);
  localparam logic [DivW-1:0]  DivLoad = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StCapture, StSetup, StHigh, StLoad, StDone
  } state_e;

  state_e              r_state, w_state_next;
  logic [DivW-1:0]     r_div, w_div_next;
  logic [AddrW-1:0]    r_pad, w_pad_next;
  logic [CntW-1:0]     r_bit, w_bit_next;
  logic [CFG_BITS-1:0] r_shift, w_shift_next;
  logic                r_busy, r_done, r_rd, r_sclk, r_sdo, r_load, r_srstn;
  logic [AddrW-1:0]    r_addr;
  logic                w_start, w_div_done;

`ifdef GPIO_CFG_AUTOSTART_EN
  logic r_autostart;

  // One-shot: armed by reset, consumed on the first IDLE cycle afterwards.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_autostart <= 1'b1;
    end else if (r_state == StIdle) begin
      r_autostart <= 1'b0;
    end
  end

  assign w_start = bus.start | r_autostart;
`else
  assign w_start = bus.start;
`endif

  assign w_div_done = (r_div == '0);

  // Next-state, divider and datapath decode.
  always_comb begin
    w_state_next = r_state;
    w_pad_next   = r_pad;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = StFetch;
          w_pad_next   = LastPad;
        end
      end
      StFetch:   w_state_next = StCapture;
      StCapture: begin
        w_state_next = StSetup;
        w_shift_next = bus.cfg_data;
        w_bit_next   = LastBit;
      end
      StSetup: begin
        if (w_div_done) w_state_next = StHigh;
      end
      StHigh: begin
        if (w_div_done) begin
          w_shift_next = {r_shift[CFG_BITS-2:0], 1'b0};
          if (r_bit != '0) begin
            w_bit_next   = r_bit - CntW'(1);
            w_state_next = StSetup;
          end else if (r_pad != '0) begin
            w_pad_next   = r_pad - AddrW'(1);
            w_state_next = StFetch;
          end else begin
            w_state_next = StLoad;
          end
        end
      end
      StLoad: begin
        if (w_div_done) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase

    // Divider reloads on every state entry so each half-period is exactly CLK_DIV cycles.
    if (w_state_next != r_state) begin
      w_div_next = DivLoad;
    end else if (!w_div_done) begin
      w_div_next = r_div - DivW'(1);
    end else begin
      w_div_next = r_div;
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_pad   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_load  <= 1'b0;
      r_srstn <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_pad   <= w_pad_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_busy  <= (w_state_next != StIdle);
      r_done  <= (w_state_next == StDone);
      r_rd    <= (w_state_next == StFetch);
      if (w_state_next == StFetch) r_addr <= w_pad_next;
      r_sclk  <= (w_state_next == StHigh);
      r_sdo   <= ((w_state_next == StSetup) || (w_state_next == StHigh)) ?
                 w_shift_next[CFG_BITS-1] : 1'b0;
      r_load  <= (w_state_next == StLoad);
      r_srstn <= 1'b1;
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.cfg_rd          = r_rd;
  assign bus.cfg_addr        = r_addr;
  assign bus.serial_clock    = r_sclk;
  assign bus.serial_data_out = r_sdo;
  assign bus.serial_load     = r_load;
  assign bus.serial_resetn   = r_srstn;
endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Bench for gpio_cfg_sequencer: a 2-pad/CLK_DIV=2 instance and a 38-pad/CLK_DIV=1 instance.
// Expected chain bits and fetch addresses are queued from the store model at start.
module tb_gpio_cfg_sequencer;
  localparam int unsigned CfgBits = 13;
  localparam int unsigned PadsA   = 2;
  localparam int unsigned DivA    = 2;
  localparam int unsigned PadsB   = 38;
  localparam int unsigned DivB    = 1;

  logic clock, rst_a_n, rst_b_n, sel_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [CfgBits-1:0] store_a [PadsA];
  logic [CfgBits-1:0] store_b [PadsB];
  bit                 bit_q[$];
  int                 addr_q[$];

  logic       m_busy, m_done, m_rd, m_sclk, m_sdo, m_load, m_srstn;
  logic [7:0] m_addr;

  int mon_busy, mon_rises, mon_high, mon_loads, mon_load_cyc, mon_dones, mon_done_cyc;
  int mon_overlap, mon_rds, mon_rd_double;

  gpio_cfg_sequencer_if #(.TOTAL_PADS(PadsA), .CFG_BITS(CfgBits)) bus_a ();
  gpio_cfg_sequencer_if #(.TOTAL_PADS(PadsB), .CFG_BITS(CfgBits)) bus_b ();

  gpio_cfg_sequencer #(.TOTAL_PADS(PadsA), .CFG_BITS(CfgBits), .CLK_DIV(DivA)) u_dut_a (
    .clock  (clock),
    .resetn (rst_a_n),
    .bus    (bus_a)
  );

  gpio_cfg_sequencer #(.TOTAL_PADS(PadsB), .CFG_BITS(CfgBits), .CLK_DIV(DivB)) u_dut_b (
    .clock  (clock),
    .resetn (rst_b_n),
    .bus    (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Config store: read data valid the cycle after cfg_rd, zero otherwise.
  always @(posedge clock) bus_a.cfg_data <= bus_a.cfg_rd ? store_a[bus_a.cfg_addr] : '0;
  always @(posedge clock) bus_b.cfg_data <= bus_b.cfg_rd ? store_b[bus_b.cfg_addr] : '0;

  always_comb begin
    if (sel_b) begin
      m_busy = bus_b.busy; m_done = bus_b.done; m_rd = bus_b.cfg_rd;
      m_addr = 8'(bus_b.cfg_addr); m_sclk = bus_b.serial_clock;
      m_sdo = bus_b.serial_data_out; m_load = bus_b.serial_load; m_srstn = bus_b.serial_resetn;
    end else begin
      m_busy = bus_a.busy; m_done = bus_a.done; m_rd = bus_a.cfg_rd;
      m_addr = 8'(bus_a.cfg_addr); m_sclk = bus_a.serial_clock;
      m_sdo = bus_a.serial_data_out; m_load = bus_a.serial_load; m_srstn = bus_a.serial_resetn;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel_b) bus_b.start = v;
    else bus_a.start = v;
  endtask

  task automatic pulse_start();
    set_start(1'b1);
    @(negedge clock);
    set_start(1'b0);
  endtask

  task automatic push_pass();
    if (sel_b) begin
      for (int p = PadsB - 1; p >= 0; p--) begin
        addr_q.push_back(p);
        for (int b = CfgBits - 1; b >= 0; b--) bit_q.push_back(store_b[p][b]);
      end
    end else begin
      for (int p = PadsA - 1; p >= 0; p--) begin
        addr_q.push_back(p);
        for (int b = CfgBits - 1; b >= 0; b--) bit_q.push_back(store_a[p][b]);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_done"}, 32'(m_done), 0);
    check({tag, "_cfg_rd"}, 32'(m_rd), 0);
    check({tag, "_cfg_addr"}, 32'(m_addr), 0);
    check({tag, "_sclk"}, 32'(m_sclk), 0);
    check({tag, "_sdo"}, 32'(m_sdo), 0);
    check({tag, "_load"}, 32'(m_load), 0);
    check({tag, "_srstn"}, 32'(m_srstn), 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int busy_seen = 0;
    repeat (n) begin
      @(negedge clock);
      if (m_busy) busy_seen++;
    end
    check(tag, busy_seen, 0);
  endtask

  // Samples one pass on negedges from the first busy cycle until busy drops or budget expires.
  task automatic mon(input int budget, input int poke);
    int   cyc    = 0;
    logic p_sclk = 1'b0;
    logic p_load = 1'b0;
    logic p_rd   = 1'b0;
    mon_busy = 0; mon_rises = 0; mon_high = 0; mon_loads = 0; mon_load_cyc = 0;
    mon_dones = 0; mon_done_cyc = -1; mon_overlap = 0; mon_rds = 0; mon_rd_double = 0;
    while (m_busy && cyc < budget) begin
      mon_busy++;
      if (m_sclk) mon_high++;
      if (m_sclk && !p_sclk) begin
        mon_rises++;
        if (bit_q.size() == 0) check("bit_underrun", 32'(bit_q.size()), 1);
        else check("serial_bit", 32'(m_sdo), 32'(bit_q.pop_front()));
      end
      if (m_sclk && m_load) mon_overlap++;
      if (m_load) begin
        mon_load_cyc++;
        if (!p_load) mon_loads++;
      end
      if (m_done) begin
        mon_dones++;
        mon_done_cyc = cyc;
      end
      if (m_rd) begin
        mon_rds++;
        if (p_rd) mon_rd_double++;
        if (addr_q.size() == 0) check("addr_underrun", 32'(addr_q.size()), 1);
        else check("cfg_addr", 32'(m_addr), 32'(addr_q.pop_front()));
      end
      if (cyc == poke) set_start(1'b1);
      if (cyc == poke + 1) set_start(1'b0);
      p_sclk = m_sclk; p_load = m_load; p_rd = m_rd;
      cyc++;
      @(negedge clock);
    end
    set_start(1'b0);
  endtask

  task automatic check_pass(input string tag, input int pads, input int div);
    int exp_busy = pads * (2 + 2 * div * CfgBits) + div + 1;
    check({tag, "_busy_cycles"}, mon_busy, exp_busy);
    check({tag, "_sclk_rises"}, mon_rises, pads * CfgBits);
    check({tag, "_sclk_high_cycles"}, mon_high, pads * CfgBits * div);
    check({tag, "_load_pulses"}, mon_loads, 1);
    check({tag, "_load_width"}, mon_load_cyc, div);
    check({tag, "_load_sclk_overlap"}, mon_overlap, 0);
    check({tag, "_done_pulses"}, mon_dones, 1);
    check({tag, "_done_last_busy"}, mon_done_cyc, mon_busy - 1);
    check({tag, "_cfg_reads"}, mon_rds, pads);
    check({tag, "_cfg_rd_double"}, mon_rd_double, 0);
    check({tag, "_bits_left"}, 32'(bit_q.size()), 0);
    check({tag, "_addrs_left"}, 32'(addr_q.size()), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_at;
    int loads_in_rst;
    rst_a_n = 1'b0; rst_b_n = 1'b0; sel_b = 1'b0;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    store_a[1] = 13'h1ABC; store_a[0] = 13'h0155;
    for (int i = 0; i < int'(PadsB); i++) store_b[i] = CfgBits'($urandom);
    repeat (3) @(negedge clock);
    check_reset("reset_a");

`ifdef GPIO_CFG_AUTOSTART_EN
    push_pass();
    rst_a_n = 1'b1;
    #1 check("srstn_at_release", 32'(m_srstn), 0);
    @(negedge clock);
    check("srstn_after_edge", 32'(m_srstn), 1);
    mon(400, -1);
    check_pass("autostart1", PadsA, DivA);
    idle_check("autostart1_single", 20);
`else
    rst_a_n = 1'b1;
    #1 check("srstn_at_release", 32'(m_srstn), 0);
    @(negedge clock);
    check("srstn_after_edge", 32'(m_srstn), 1);
    idle_check("no_start_no_pass", 20);
`endif

    // Basic pass: 1ABC then 0155.
    push_pass();
    pulse_start();
    mon(400, -1);
    check_pass("basic", PadsA, DivA);

    // Extreme patterns.
    store_a[1] = 13'h1FFF; store_a[0] = 13'h0000;
    push_pass();
    pulse_start();
    mon(400, -1);
    check_pass("ones_zeros", PadsA, DivA);

    // start mid-shift is ignored and not queued.
    store_a[1] = 13'h0A5A; store_a[0] = 13'h15A5;
    push_pass();
    pulse_start();
    mon(400, 30);
    check_pass("start_in_busy", PadsA, DivA);
    idle_check("start_in_busy_no_requeue", 20);

    // Reset during pad 0 shifting.
    push_pass();
    pulse_start();
    mon(70, -1);
    check("midrst_prefix_cycles", mon_busy, 70);
    rst_a_n = 1'b0;
    #1 check_reset("midrst");
    bit_q.delete();
    addr_q.delete();
    loads_in_rst = 0;
    repeat (5) begin
      @(negedge clock);
      if (m_load) loads_in_rst++;
    end
    check("midrst_no_load", loads_in_rst, 0);
`ifdef GPIO_CFG_AUTOSTART_EN
    push_pass();
`endif
    rst_a_n = 1'b1;
    #1 check("midrst_srstn_at_release", 32'(m_srstn), 0);
    @(negedge clock);
    check("midrst_srstn_after_edge", 32'(m_srstn), 1);
`ifdef GPIO_CFG_AUTOSTART_EN
    mon(400, -1);
    check_pass("autostart2", PadsA, DivA);
    idle_check("autostart2_single", 30);
`else
    idle_check("midrst_no_resume", 30);
`endif

    // 38 pads, CLK_DIV=1.
    sel_b = 1'b1;
    #1 check_reset("reset_b");
`ifdef GPIO_CFG_AUTOSTART_EN
    push_pass();
    rst_b_n = 1'b1;
    @(negedge clock);
    mon(2000, -1);
    check_pass("b_autostart", PadsB, DivB);
`else
    rst_b_n = 1'b1;
    @(negedge clock);
`endif
    push_pass();
    pulse_start();
    busy_at = 32'(m_busy);
    check("b_busy_after_start", busy_at, 1);
    mon(2000, -1);
    check_pass("b_div1", PadsB, DivB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
